// File: rtl/prog_ctr_seq.sv
// prog_ctr_seq: instruction-fetch program counter with an IDLE/RUN/DONE sequencer,
// absolute and PC-relative branches, and an optional hardware call/return stack.
// Optional feature macro: PC_CALL_STACK_EN (return stack, StackErr and Depth live).
// Without the macro, Call/Ret are ignored and StackErr/Depth read as zero.
module prog_ctr_seq #(
    parameter int unsigned PC_W        = 10,
    parameter int unsigned STACK_DEPTH = 4,
    localparam int unsigned DW         = $clog2(STACK_DEPTH + 1)
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic [PC_W-1:0] StartAddr,
    input  logic            Jen,
    input  logic            Rel,
    input  logic [PC_W-1:0] Jump,
    input  logic            Call,
    input  logic            Ret,
    input  logic            Halt,
    output logic [PC_W-1:0] PC,
    output logic            Running,
    output logic            Done,
    output logic            StackErr,
    output logic [DW-1:0]   Depth
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            err_q, err_d;
    logic [DW-1:0]   depth_q, depth_d;
    logic [PC_W-1:0] pc_inc;
    logic            push_en;

    assign pc_inc = pc_q + PC_W'(1);

`ifdef PC_CALL_STACK_EN
    localparam int unsigned IdxW      = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [DW-1:0] DepthFull = DW'(STACK_DEPTH);

    logic [PC_W-1:0] stack_q [STACK_DEPTH];
    logic [IdxW-1:0] push_idx, pop_idx;

    assign push_idx = depth_q[IdxW-1:0];
    assign pop_idx  = IdxW'(depth_q - DW'(1));

    // Return-address storage; contents are don't-care after reset, so no reset needed.
    always_ff @(posedge Clk) begin
        if (push_en) begin
            stack_q[push_idx] <= pc_inc;
        end
    end
`else
    logic unused_stack;
    assign unused_stack = ^{Call, Ret};
`endif

    // Sequencer next-state and PC update, one action per RUN cycle in priority order.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        err_d   = err_q;
        depth_d = depth_q;
        push_en = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (Start) begin
                    pc_d    = StartAddr;
                    depth_d = '0;
                    err_d   = 1'b0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (Halt) begin
                    state_d = StDone;
                end
`ifdef PC_CALL_STACK_EN
                else if (Ret) begin
                    if (depth_q != '0) begin
                        pc_d    = stack_q[pop_idx];
                        depth_d = depth_q - DW'(1);
                    end else begin
                        // Underflow: behave like a plain increment and flag it.
                        pc_d  = pc_inc;
                        err_d = 1'b1;
                    end
                end
                else if (Call) begin
                    pc_d = Jump;
                    if (depth_q != DepthFull) begin
                        push_en = 1'b1;
                        depth_d = depth_q + DW'(1);
                    end else begin
                        // Overflow: branch still taken, return address lost.
                        err_d = 1'b1;
                    end
                end
`endif
                else if (Jen) begin
                    pc_d = Rel ? (pc_q + Jump) : Jump;
                end
                else begin
                    pc_d = pc_inc;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; asynchronous reset clears outputs and invalidates the stack.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= StIdle;
            pc_q    <= '0;
            err_q   <= 1'b0;
            depth_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
            depth_q <= depth_d;
        end
    end

    assign PC       = pc_q;
    assign Running  = (state_q == StRun);
    assign Done     = (state_q == StDone);
    assign StackErr = err_q;
    assign Depth    = depth_q;

endmodule

// File: tb/tb_prog_ctr_seq.sv
// Scoreboard bench for prog_ctr_seq: stimulus pushes expected outputs per cycle,
// monitors pop and compare after each rising edge (or after an async reset drop).
module tb_prog_ctr_seq;

    localparam int unsigned PC_W = 10;
    localparam int unsigned SD   = 4;
    localparam int unsigned DW   = $clog2(SD + 1);
`ifdef PC_CALL_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic            Clk = 1'b0;
    logic            Reset;
    logic            Start;
    logic [PC_W-1:0] StartAddr;
    logic            Jen;
    logic            Rel;
    logic [PC_W-1:0] Jump;
    logic            Call;
    logic            Ret;
    logic            Halt;
    logic [PC_W-1:0] PC;
    logic            Running;
    logic            Done;
    logic            StackErr;
    logic [DW-1:0]   Depth;

    prog_ctr_seq #(.PC_W(PC_W), .STACK_DEPTH(SD)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .StartAddr(StartAddr),
        .Jen      (Jen),
        .Rel      (Rel),
        .Jump     (Jump),
        .Call     (Call),
        .Ret      (Ret),
        .Halt     (Halt),
        .PC       (PC),
        .Running  (Running),
        .Done     (Done),
        .StackErr (StackErr),
        .Depth    (Depth)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string           nm;
        logic [PC_W-1:0] pc;
        logic            run;
        logic            done;
        logic            err;
        logic [DW-1:0]   dep;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    event async_ev;

    task automatic compare_top();
        exp_t e;
        e = sb.pop_front();
        n_cmp++;
        if (PC !== e.pc || Running !== e.run || Done !== e.done ||
            StackErr !== e.err || Depth !== e.dep) begin
            n_bad++;
            $display("FAIL %s: got pc=%0d run=%b done=%b err=%b dep=%0d, want pc=%0d run=%b done=%b err=%b dep=%0d",
                     e.nm, PC, Running, Done, StackErr, Depth,
                     e.pc, e.run, e.done, e.err, e.dep);
        end
    endtask

    // Edge monitor: one expectation per clocked cycle.
    always @(posedge Clk) begin
        #1;
        if (sb.size() > 0) compare_top();
    end

    // Async monitor: checks between edges after Reset is dropped.
    always @(async_ev) begin
        #1;
        if (sb.size() > 0) compare_top();
    end

    task automatic idle_in();
        Start = 0; StartAddr = '0; Jen = 0; Rel = 0; Jump = '0;
        Call = 0; Ret = 0; Halt = 0;
    endtask

    // Inputs already applied at a negedge; queue the post-edge expectation and advance.
    task automatic cyc(input string nm, input int pc, input bit run, input bit done,
                       input bit err, input int dep);
        exp_t e;
        e.nm = nm; e.pc = PC_W'(pc); e.run = run; e.done = done; e.err = err;
        e.dep = DW'(dep);
        sb.push_back(e);
        @(negedge Clk);
        idle_in();
    endtask

    task automatic br(input string nm, input bit rel, input int jmp, input int pc,
                      input bit err, input int dep);
        Jen = 1; Rel = rel; Jump = PC_W'(jmp);
        cyc(nm, pc, 1, 0, err, dep);
    endtask

    initial begin
        exp_t e;
        idle_in();
        Reset = 0;
        repeat (2) @(negedge Clk);
        Reset = 1;
        cyc("idle0", 0, 0, 0, 0, 0);
        cyc("idle1", 0, 0, 0, 0, 0);

        Start = 1; StartAddr = 3;
        cyc("start3", 3, 1, 0, 0, 0);
        cyc("inc4", 4, 1, 0, 0, 0);

        br("abs10", 0, 10, 10, 0, 0);
        cyc("inc11", 11, 1, 0, 0, 0);
        br("rel-6", 1, 10'h3FA, 5, 0, 0);
        br("abs1023", 0, 1023, 1023, 0, 0);
        cyc("wrap0", 0, 1, 0, 0, 0);
        br("rel-1", 1, 10'h3FF, 1023, 0, 0);
        cyc("wrap0b", 0, 1, 0, 0, 0);
        br("abs20", 0, 20, 20, 0, 0);

        if (STK) begin
            Call = 1; Jump = 100; cyc("call100", 100, 1, 0, 0, 1);
            Ret = 1;              cyc("ret21", 21, 1, 0, 0, 0);
            Call = 1; Jump = 200; cyc("call1", 200, 1, 0, 0, 1);
            Call = 1; Jump = 201; cyc("call2", 201, 1, 0, 0, 2);
            Call = 1; Jump = 202; cyc("call3", 202, 1, 0, 0, 3);
            Call = 1; Jump = 203; cyc("call4", 203, 1, 0, 0, 4);
            Call = 1; Jump = 204; cyc("call5ovf", 204, 1, 0, 1, 4);
            Ret = 1; cyc("pop203", 203, 1, 0, 1, 3);
            Ret = 1; cyc("pop202", 202, 1, 0, 1, 2);
            Ret = 1; cyc("pop201", 201, 1, 0, 1, 1);
            Ret = 1; cyc("pop22", 22, 1, 0, 1, 0);
            Ret = 1; Jen = 1; Jump = 500; cyc("retunf", 23, 1, 0, 1, 0);
        end else begin
            Call = 1; Jump = 100; cyc("callign", 21, 1, 0, 0, 0);
            Ret = 1; Jen = 1; Jump = 30; cyc("retign", 30, 1, 0, 0, 0);
        end

        br("abs7", 0, 7, 7, STK, 0);
        Halt = 1; Call = 1; Jen = 1; Jump = 99;
        cyc("halt", 7, 0, 1, STK, 0);
        Jen = 1; Call = 1; Ret = 1; Jump = 5;
        cyc("doneign", 7, 0, 1, STK, 0);
        cyc("donehold", 7, 0, 1, STK, 0);
        Start = 1; StartAddr = 50;
        cyc("restart50", 50, 1, 0, 0, 0);
        Start = 1; StartAddr = 900;
        cyc("startinrun", 51, 1, 0, 0, 0);

        br("abs42", 0, 42, 42, 0, 0);
        #2;
        Reset = 0;
        e.nm = "asyncrst"; e.pc = '0; e.run = 0; e.done = 0; e.err = 0; e.dep = '0;
        sb.push_back(e);
        -> async_ev;
        @(negedge Clk);
        cyc("inreset", 0, 0, 0, 0, 0);
        Reset = 1;
        cyc("postrst", 0, 0, 0, 0, 0);

        repeat (2) @(negedge Clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
